spi_slave: RTL and testbench
============================

Name: spi_slave

Overview:
Byte-oriented SPI peripheral (slave) that is the far end of the team's SPI_Master link. It oversamples an external SPI clock, chip-select and MOSI in the i_Clk domain. It shifts in received bytes on MOSI and shifts out staged response bytes on MISO, MSb first, in any of the four SPI modes. It is used on the FPGA side to emulate a chip's SPI port, and for loopback verification of the master.

Parameters:
SPI_MODE, 1, SPI mode 0-3. CPOL = mode 2 or 3; CPHA = mode 1 or 3; same encoding as the team's master.
DEFAULT_TX, 8'hFF, byte shifted out on MISO when no TX byte is staged (underrun).

Ports:
i_Clk  input  1  system clock; must be >= 8x the SPI clock (SPI half-period >= 4 i_Clk cycles)
i_Rst_L  input  1  asynchronous, active-low reset
i_TX_Byte  input  8  response byte to stage
i_TX_DV  input  1  1-cycle pulse; stages i_TX_Byte
o_TX_Ready  output  1  high when the staging register is empty
o_RX_DV  output  1  1-cycle pulse; o_RX_Byte is valid
o_RX_Byte  output  8  last complete byte received on MOSI
i_SPI_Clk  input  1  SPI clock from master (asynchronous)
i_SPI_CS_n  input  1  chip-select, active low (asynchronous)
i_SPI_MOSI  input  1  serial data in
o_SPI_MISO  output  1  serial data out
o_SPI_MISO_En  output  1  MISO output enable (drives top-level tristate)

Behaviour:
- Reset (async, i_Rst_L=0):
  - o_RX_DV=0, o_RX_Byte=8'h00, o_SPI_MISO=0, o_SPI_MISO_En=0, o_TX_Ready=1.
  - Staging register empty; bit counters = 7.
  - State = IDLE.
  - Reset mid-byte discards all partial data.
- Synchronisation:
  - i_SPI_Clk, i_SPI_CS_n and i_SPI_MOSI each pass through a 2-flop synchroniser, plus a 3rd flop for edge detect. All three share equal delay.
  - Leading edge = rising edge if CPOL=0, falling edge if CPOL=1. Trailing edge is the opposite transition.
  - Sample edge = leading edge if CPHA=0, trailing edge if CPHA=1. Shift edge = the other edge.
- State machine (2 states):
  - IDLE → ACTIVE on synchronised CS_n falling edge.
  - ACTIVE → IDLE on synchronised CS_n rising edge.
  - ACTIVE→IDLE from any bit position: RX bit count resets to 7, partial RX byte is dropped (no o_RX_DV), MISO_En→0, MISO→0.
  - SPI clock edges in IDLE are ignored.
- Byte load: the TX shift register loads at (a) IDLE→ACTIVE and (b) the shift edge that follows the 8th sample edge of a byte while CS remains asserted.
  - Load source: staging register if full (staging then empties, o_TX_Ready→1 next cycle); otherwise DEFAULT_TX.
- MISO:
  - o_SPI_MISO_En=1 throughout ACTIVE.
  - CPHA=0: bit7 is driven on the cycle after IDLE→ACTIVE. Each following shift edge drives the next bit; the 8th shift edge loads and drives bit7 of the next byte.
  - CPHA=1: MISO is driven only on shift (leading) edges. The first leading edge of a byte drives bit7.
  - Value is registered: it changes 3 i_Clk cycles after the pin edge, which is within the half-period limit.
- RX:
  - On each sample edge, the synchronised MOSI shifts in MSb first and the bit count decrements.
  - On the 8th sample: o_RX_Byte updates and o_RX_DV pulses high for exactly 1 cycle, 3 i_Clk cycles after the i_SPI_Clk pin edge. Bit count wraps to 7.
  - o_RX_Byte holds its value until the next complete byte.
- TX staging:
  - i_TX_DV=1 writes i_TX_Byte to staging; o_TX_Ready=0 from the next cycle.
  - i_TX_DV while already full: overwrite, last write wins.
  - i_TX_DV in the same cycle as a load: the load uses the old staging content (DEFAULT_TX if empty). The new byte stays staged and o_TX_Ready=0.
- Back-to-back bytes under continuous CS: no idle gap is required. o_RX_DV pulses once per byte.

Test Plan:
1. Mode 1 loopback against the team's SPI_Master (CLKS_PER_HALF_BIT=4). Stage slave 0x3C, CS low, master sends 0xA5 → slave o_RX_Byte=0xA5 with a single o_RX_DV pulse; master receives 0x3C; o_TX_Ready returns to 1.
2. Mode 0, CS held, master sends 0x01,0x02,0x03; slave stages 0x11,0x22,0x33, each after the prior load → three o_RX_DV pulses with 0x01/0x02/0x03; master receives 0x11/0x22/0x33.
3. Underrun: no staged byte, master sends 0x5A → master receives 0xFF; slave receives 0x5A.
4. CS abort: CS high after 5 sample edges of 0xF0, then CS low and a full 0x0F → no o_RX_DV for the aborted byte; the next byte yields exactly 0x0F.
5. Modes 2 and 3 with byte 0xC3 both ways → correct bytes; MISO_En=0 whenever CS_n=1.
6. Assert i_Rst_L=0 mid-byte (after 4 bits) → all outputs at reset values immediately. After release, a full 0x96 transfer is received correctly.

Source files
------------

// File: rtl/spi_slave.sv
// Byte-oriented SPI slave: oversamples SPI clock/CS/MOSI in the i_Clk domain, receives on MOSI
// and returns staged response bytes on MISO, MSb first, in any of the four SPI modes.
module spi_slave #(
  parameter int         SPI_MODE   = 1,
  parameter logic [7:0] DEFAULT_TX = 8'hFF
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic [7:0] i_TX_Byte,
  input  logic       i_TX_DV,
  output logic       o_TX_Ready,
  output logic       o_RX_DV,
  output logic [7:0] o_RX_Byte,
  input  logic       i_SPI_Clk,
  input  logic       i_SPI_CS_n,
  input  logic       i_SPI_MOSI,
  output logic       o_SPI_MISO,
  output logic       o_SPI_MISO_En
);

  // state  | meaning
  // IDLE   | CS_n deasserted; SPI clock edges ignored, MISO released
  // ACTIVE | CS_n asserted; shifting bytes in on MOSI and out on MISO
  typedef enum logic {IDLE, ACTIVE} state_t;

  localparam logic CPOL = (SPI_MODE == 2) || (SPI_MODE == 3);
  localparam logic CPHA = (SPI_MODE == 1) || (SPI_MODE == 3);

  state_t      state_q;
  logic [2:0]  sclk_q;
  logic [2:0]  cs_q;
  logic [1:0]  mosi_q;
  logic [6:0]  rx_sr_q;
  logic [2:0]  rx_cnt_q;
  logic [7:0]  rx_byte_q;
  logic        rx_dv_q;
  logic [7:0]  tx_sr_q;
  logic        miso_q;
  logic        miso_en_q;
  logic        load_pend_q;
  logic [7:0]  stage_q;
  logic        stage_full_q;

  logic        cs_fall, cs_rise;
  logic        sclk_rise, sclk_fall;
  logic        lead_edge, trail_edge;
  logic        sample_edge, shift_edge;
  logic        load_now;
  logic [7:0]  load_byte;
  logic [7:0]  shift_src;

  // Index [1] is the synchronised level, [2] its previous value for edge detect.
  assign cs_fall     = cs_q[2] & ~cs_q[1];
  assign cs_rise     = ~cs_q[2] & cs_q[1];
  assign sclk_rise   = ~sclk_q[2] & sclk_q[1];
  assign sclk_fall   = sclk_q[2] & ~sclk_q[1];
  assign lead_edge   = CPOL ? sclk_fall : sclk_rise;
  assign trail_edge  = CPOL ? sclk_rise : sclk_fall;
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign shift_edge  = CPHA ? lead_edge : trail_edge;

  assign load_byte = stage_full_q ? stage_q : DEFAULT_TX;
  assign shift_src = load_pend_q ? load_byte : tx_sr_q;
  assign load_now  = ((state_q == IDLE) && cs_fall) ||
                     ((state_q == ACTIVE) && !cs_rise && shift_edge && load_pend_q);

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q      <= IDLE;
      sclk_q       <= {3{CPOL}};
      cs_q         <= 3'b111;
      mosi_q       <= 2'b00;
      rx_sr_q      <= 7'h00;
      rx_cnt_q     <= 3'd7;
      rx_byte_q    <= 8'h00;
      rx_dv_q      <= 1'b0;
      tx_sr_q      <= 8'h00;
      miso_q       <= 1'b0;
      miso_en_q    <= 1'b0;
      load_pend_q  <= 1'b0;
      stage_q      <= 8'h00;
      stage_full_q <= 1'b0;
    end else begin
      sclk_q  <= {sclk_q[1:0], i_SPI_Clk};
      cs_q    <= {cs_q[1:0], i_SPI_CS_n};
      mosi_q  <= {mosi_q[0], i_SPI_MOSI};
      rx_dv_q <= 1'b0;

      // A write coinciding with a load keeps the new byte staged; the load used the old one.
      if (i_TX_DV) begin
        stage_q      <= i_TX_Byte;
        stage_full_q <= 1'b1;
      end else if (load_now) begin
        stage_full_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (cs_fall) begin
            state_q     <= ACTIVE;
            miso_en_q   <= 1'b1;
            rx_cnt_q    <= 3'd7;
            load_pend_q <= 1'b0;
            if (!CPHA) begin
              miso_q  <= load_byte[7];
              tx_sr_q <= {load_byte[6:0], 1'b0};
            end else begin
              tx_sr_q <= load_byte;
            end
          end
        end
        ACTIVE: begin
          if (cs_rise) begin
            state_q     <= IDLE;
            miso_en_q   <= 1'b0;
            miso_q      <= 1'b0;
            rx_cnt_q    <= 3'd7;
            load_pend_q <= 1'b0;
          end else begin
            if (sample_edge) begin
              rx_sr_q <= {rx_sr_q[5:0], mosi_q[1]};
              if (rx_cnt_q == 3'd0) begin
                rx_byte_q   <= {rx_sr_q, mosi_q[1]};
                rx_dv_q     <= 1'b1;
                rx_cnt_q    <= 3'd7;
                load_pend_q <= 1'b1;
              end else begin
                rx_cnt_q <= rx_cnt_q - 3'd1;
              end
            end
            if (shift_edge) begin
              miso_q      <= shift_src[7];
              tx_sr_q     <= {shift_src[6:0], 1'b0};
              load_pend_q <= 1'b0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_TX_Ready    = ~stage_full_q;
  assign o_RX_DV       = rx_dv_q;
  assign o_RX_Byte     = rx_byte_q;
  assign o_SPI_MISO    = miso_q;
  assign o_SPI_MISO_En = miso_en_q;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: one instance per SPI mode, driven by a behavioural SPI master
// with a half-period of 4 i_Clk cycles.
module tb_spi_slave;

  logic       i_Clk = 1'b0;
  logic       i_Rst_L;
  logic [3:0] tx_dv, tx_ready, rx_dv, sclk, cs_n, mosi, miso, miso_en;
  logic [7:0] tx_byte [4];
  logic [7:0] rx_byte [4];
  int         dv_cnt  [4] = '{0, 0, 0, 0};

  int n_vec = 0;
  int n_err = 0;

  always #5 i_Clk = ~i_Clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    spi_slave #(.SPI_MODE(g), .DEFAULT_TX(8'hFF)) u_dut (
      .i_Clk         (i_Clk),
      .i_Rst_L       (i_Rst_L),
      .i_TX_Byte     (tx_byte[g]),
      .i_TX_DV       (tx_dv[g]),
      .o_TX_Ready    (tx_ready[g]),
      .o_RX_DV       (rx_dv[g]),
      .o_RX_Byte     (rx_byte[g]),
      .i_SPI_Clk     (sclk[g]),
      .i_SPI_CS_n    (cs_n[g]),
      .i_SPI_MOSI    (mosi[g]),
      .o_SPI_MISO    (miso[g]),
      .o_SPI_MISO_En (miso_en[g])
    );
  end

  // Counts high cycles of each o_RX_DV, so a stretched pulse shows up as an extra count.
  always @(negedge i_Clk)
    for (int i = 0; i < 4; i++)
      if (rx_dv[i]) dv_cnt[i]++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic half();
    repeat (4) @(negedge i_Clk);
  endtask

  task automatic stage(input int m, input logic [7:0] b);
    @(negedge i_Clk);
    tx_byte[m] = b;
    tx_dv[m]   = 1'b1;
    @(negedge i_Clk);
    tx_dv[m]   = 1'b0;
  endtask

  task automatic cs_low(input int m);
    cs_n[m] = 1'b0;
    half();
  endtask

  task automatic cs_high(input int m);
    cs_n[m] = 1'b1;
    half();
    half();
  endtask

  task automatic xfer(input int m, input logic [7:0] b, input int nbits, output logic [7:0] r);
    bit cpha = (m == 1) || (m == 3);
    r = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      if (!cpha) begin
        mosi[m] = b[i];
        half();
        r[i]    = miso[m];
        sclk[m] = ~sclk[m];
        half();
        sclk[m] = ~sclk[m];
      end else begin
        sclk[m] = ~sclk[m];
        mosi[m] = b[i];
        half();
        r[i]    = miso[m];
        sclk[m] = ~sclk[m];
        half();
      end
    end
  endtask

  initial begin
    logic [7:0] r, r1, r2, r3;
    int d;

    sclk    = 4'b1100;
    cs_n    = 4'hF;
    mosi    = 4'h0;
    tx_dv   = 4'h0;
    for (int i = 0; i < 4; i++) tx_byte[i] = 8'h00;
    i_Rst_L = 1'b0;
    repeat (3) @(negedge i_Clk);

    check("rst_rx_dv",    32'(rx_dv),      32'h0);
    check("rst_rx_byte",  32'(rx_byte[1]), 32'h00);
    check("rst_miso",     32'(miso),       32'h0);
    check("rst_miso_en",  32'(miso_en),    32'h0);
    check("rst_tx_ready", 32'(tx_ready),   32'hF);
    i_Rst_L = 1'b1;
    repeat (4) @(negedge i_Clk);

    // Mode 1 loopback.
    d = dv_cnt[1];
    stage(1, 8'h3C);
    check("m1_ready_staged", 32'(tx_ready[1]), 32'h0);
    cs_low(1);
    check("m1_ready_loaded", 32'(tx_ready[1]), 32'h1);
    check("m1_en_active",    32'(miso_en[1]),  32'h1);
    xfer(1, 8'hA5, 8, r);
    half();
    check("m1_master_rx", 32'(r),          32'h3C);
    check("m1_slave_rx",  32'(rx_byte[1]), 32'hA5);
    check("m1_dv_count",  32'(dv_cnt[1] - d), 32'h1);
    cs_high(1);
    check("m1_en_idle",   32'(miso_en[1]), 32'h0);

    // Mode 0, three bytes under continuous CS.
    d = dv_cnt[0];
    stage(0, 8'h11);
    cs_low(0);
    stage(0, 8'h22);
    xfer(0, 8'h01, 8, r1);
    half();
    check("m0_rx_b1", 32'(rx_byte[0]), 32'h01);
    stage(0, 8'h33);
    xfer(0, 8'h02, 8, r2);
    half();
    check("m0_rx_b2", 32'(rx_byte[0]), 32'h02);
    xfer(0, 8'h03, 8, r3);
    half();
    check("m0_rx_b3", 32'(rx_byte[0]), 32'h03);
    cs_high(0);
    check("m0_master_b1", 32'(r1), 32'h11);
    check("m0_master_b2", 32'(r2), 32'h22);
    check("m0_master_b3", 32'(r3), 32'h33);
    check("m0_dv_count",  32'(dv_cnt[0] - d), 32'h3);

    // Underrun.
    d = dv_cnt[0];
    cs_low(0);
    xfer(0, 8'h5A, 8, r);
    half();
    cs_high(0);
    check("ur_master_rx", 32'(r),          32'hFF);
    check("ur_slave_rx",  32'(rx_byte[0]), 32'h5A);
    check("ur_dv_count",  32'(dv_cnt[0] - d), 32'h1);

    // CS abort after 5 sample edges, then a clean byte.
    d = dv_cnt[0];
    cs_low(0);
    xfer(0, 8'hF0, 5, r);
    half();
    cs_high(0);
    check("abort_no_dv",   32'(dv_cnt[0] - d), 32'h0);
    check("abort_rx_hold", 32'(rx_byte[0]),    32'h5A);
    cs_low(0);
    xfer(0, 8'h0F, 8, r);
    half();
    cs_high(0);
    check("abort_next_rx", 32'(rx_byte[0]),    32'h0F);
    check("abort_next_dv", 32'(dv_cnt[0] - d), 32'h1);
    check("abort_master",  32'(r),             32'hFF);

    // Modes 2 and 3.
    for (int m = 2; m < 4; m++) begin
      d = dv_cnt[m];
      stage(m, 8'hC3);
      check($sformatf("m%0d_en_before", m), 32'(miso_en[m]), 32'h0);
      cs_low(m);
      check($sformatf("m%0d_en_active", m), 32'(miso_en[m]), 32'h1);
      xfer(m, 8'hC3, 8, r);
      half();
      cs_high(m);
      check($sformatf("m%0d_master_rx", m), 32'(r),          32'hC3);
      check($sformatf("m%0d_slave_rx", m),  32'(rx_byte[m]), 32'hC3);
      check($sformatf("m%0d_dv_count", m),  32'(dv_cnt[m] - d), 32'h1);
      check($sformatf("m%0d_en_after", m),  32'(miso_en[m]), 32'h0);
    end

    // Reset mid-byte on the mode 1 instance.
    cs_low(1);
    stage(1, 8'h77);
    xfer(1, 8'h96, 4, r);
    i_Rst_L = 1'b0;
    #1;
    check("mrst_rx_dv",    32'(rx_dv[1]),    32'h0);
    check("mrst_rx_byte",  32'(rx_byte[1]),  32'h00);
    check("mrst_miso",     32'(miso[1]),     32'h0);
    check("mrst_miso_en",  32'(miso_en[1]),  32'h0);
    check("mrst_tx_ready", 32'(tx_ready[1]), 32'h1);
    cs_n[1] = 1'b1;
    sclk[1] = 1'b0;
    repeat (4) @(negedge i_Clk);
    i_Rst_L = 1'b1;
    repeat (4) @(negedge i_Clk);
    d = dv_cnt[1];
    cs_low(1);
    xfer(1, 8'h96, 8, r);
    half();
    cs_high(1);
    check("post_rst_rx",     32'(rx_byte[1]),     32'h96);
    check("post_rst_dv",     32'(dv_cnt[1] - d),  32'h1);
    check("post_rst_master", 32'(r),              32'hFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
